// File: rtl/led_tff_sched_pkg.sv
// Shared mode encodings and default sizing for the LED T flip-flop scheduler.
package led_tff_sched_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'd0,
      MODE_BLINK = 2'd1,
      MODE_CHASE = 2'd2,
      MODE_COUNT = 2'd3
   } mode_e;

   localparam int DEF_TICK_DIV = 12000000;
   localparam int DEF_NUM_LEDS = 5;

   function automatic mode_e next_mode(input mode_e m);
      mode_e n;
      case (m)
         MODE_IDLE:  n = MODE_BLINK;
         MODE_BLINK: n = MODE_CHASE;
         MODE_CHASE: n = MODE_COUNT;
         default:    n = MODE_IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/led_tff_sched_tff_cell.sv
// Single T flip-flop: flips its output on every clock edge where t_i is high.
module tff_cell (
   input  logic clk,
   input  logic rst,
   input  logic t_i,
   output logic q_o
);

   logic q_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= 1'b0;
      end else if (t_i) begin
         q_q <= ~q_q;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/led_tff_sched.sv
// Pattern scheduler for a bank of LED T flip-flops; all LED changes, including
// clearing on a mode change, are expressed as toggles.
//
// state      | meaning
// MODE_IDLE  | prescaler held at 0, LEDs left off
// MODE_BLINK | every tick flips all LEDs
// MODE_CHASE | every tick moves a single lit LED one position up
// MODE_COUNT | every tick increments the LED word as a binary counter
module led_tff_sched
   import led_tff_sched_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int NUM_LEDS = DEF_NUM_LEDS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mode_btn,
   input  logic                run,
   output logic [NUM_LEDS-1:0] tog,
   output logic [NUM_LEDS-1:0] led,
   output logic [1:0]          mode
);

   localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int STEP_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(TICK_DIV - 1);
   localparam logic [STEP_W-1:0]   STEP_MAX = STEP_W'(NUM_LEDS - 1);
   localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);

   logic                btn_s1_q;
   logic                btn_s2_q;
   logic                btn_prev_q;
   logic [1:0]          arm_q;
   mode_e               mode_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [STEP_W-1:0]   step_q;
   logic                mode_adv;
   logic                tick;
   logic [NUM_LEDS-1:0] tog_c;
   logic [NUM_LEDS-1:0] led_bank;

   // The edge detector's history flop resets high and only starts following the
   // synchroniser once it carries real samples, so a button already held during
   // reset is not mistaken for a fresh press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_s1_q   <= 1'b0;
         btn_s2_q   <= 1'b0;
         btn_prev_q <= 1'b1;
         arm_q      <= 2'b00;
      end else begin
         btn_s1_q   <= mode_btn;
         btn_s2_q   <= btn_s1_q;
         arm_q      <= {arm_q[0], 1'b1};
         btn_prev_q <= arm_q[1] ? btn_s2_q : 1'b1;
      end
   end

   assign mode_adv = btn_s2_q & ~btn_prev_q;
   assign tick     = run && (mode_q != MODE_IDLE) && (cnt_q == CNT_MAX);

   // A mode change takes priority over a coincident tick: that tick is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q <= MODE_IDLE;
         cnt_q  <= '0;
         step_q <= '0;
      end else if (mode_adv) begin
         mode_q <= next_mode(mode_q);
         cnt_q  <= '0;
         step_q <= '0;
      end else if (mode_q == MODE_IDLE) begin
         cnt_q  <= '0;
         step_q <= '0;
      end else if (run) begin
         cnt_q <= tick ? '0 : cnt_q + 1'b1;
         if (tick && (mode_q == MODE_CHASE)) begin
            step_q <= (step_q == STEP_MAX) ? '0 : step_q + 1'b1;
         end
      end
   end

   always_comb begin
      tog_c = '0;
      if (mode_adv) begin
         tog_c = led_bank;
      end else if (tick) begin
         case (mode_q)
            MODE_BLINK: tog_c = '1;
            MODE_CHASE: tog_c = led_bank ^ (LED_ONE << step_q);
            MODE_COUNT: tog_c = led_bank ^ (led_bank + LED_ONE);
            default:    tog_c = '0;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
      tff_cell u_tff (
         .clk (clk),
         .rst (rst),
         .t_i (tog_c[i]),
         .q_o (led_bank[i])
      );
   end

   assign tog  = tog_c;
   assign led  = led_bank;
   assign mode = mode_q;

endmodule
